// File: rtl/md_unit.sv
// Iterative MIPS multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// HI/LO register pair with mthi/mtlo writes and an mfhi/mflo read mux.
module md_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            wr_hi,
    input  logic            wr_lo,
    input  logic [XLEN-1:0] wdata,
    input  logic            rd_hi,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] md_result
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam int unsigned AW = 2 * XLEN;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   count, count_next;
    logic [XLEN-1:0] opa, opa_next, opb, opb_next;
    logic [XLEN-1:0] hi_next, lo_next;
    logic [AW-1:0]   acc, acc_next;
    logic [1:0]      op_q, op_q_next;
    logic            sign_a, sign_a_next, sign_b, sign_b_next;
    logic            busy_next, done_next;

    logic            s_a, s_b, neg;
    logic [XLEN-1:0] a_abs, b_abs, quot, rem, raw_a, rem_sub;
    logic [XLEN:0]   add_sum, rem_sh;
    logic            rem_ge;
    logic [AW-1:0]   product;

    // Next-state and datapath logic
    always_comb begin
        state_next  = state;
        count_next  = count;
        opa_next    = opa;
        opb_next    = opb;
        acc_next    = acc;
        op_q_next   = op_q;
        sign_a_next = sign_a;
        sign_b_next = sign_b;
        hi_next     = hi;
        lo_next     = lo;
        busy_next   = busy;
        done_next   = 1'b0;

        s_a     = ~op[0] & a[XLEN-1];
        s_b     = ~op[0] & b[XLEN-1];
        a_abs   = s_a ? -a : a;
        b_abs   = s_b ? -b : b;
        add_sum = {1'b0, acc[AW-1:XLEN]} + {1'b0, opa};
        rem_sh  = acc[AW-2:XLEN-1];
        rem_ge  = rem_sh >= {1'b0, opb};
        rem_sub = XLEN'(rem_sh - {1'b0, opb});
        neg     = ~op_q[0] & (sign_a ^ sign_b);
        product = neg ? -acc : acc;
        quot    = acc[XLEN-1:0];
        rem     = acc[AW-1:XLEN];
        raw_a   = sign_a ? -opa : opa;

        case (state)
            IDLE: begin
                if (start) begin
                    opa_next    = a_abs;
                    opb_next    = b_abs;
                    acc_next    = {{XLEN{1'b0}}, (op[1] ? a_abs : b_abs)};
                    op_q_next   = op;
                    sign_a_next = s_a;
                    sign_b_next = s_b;
                    count_next  = '0;
                    busy_next   = 1'b1;
                    state_next  = op[1] ? DIV : MUL;
                end else begin
                    if (wr_hi) hi_next = wdata;
                    if (wr_lo) lo_next = wdata;
                end
            end
            MUL: begin
                acc_next   = acc[0] ? {add_sum, acc[XLEN-1:1]} : {1'b0, acc[AW-1:1]};
                count_next = count + 1'b1;
                if (count == CW'(XLEN - 1)) state_next = FIX;
            end
            DIV: begin
                acc_next   = rem_ge ? {rem_sub, acc[XLEN-2:0], 1'b1} : {acc[AW-2:0], 1'b0};
                count_next = count + 1'b1;
                if (count == CW'(XLEN - 1)) state_next = FIX;
            end
            FIX: begin
                // Divide by zero bypasses the sign fix and returns the raw dividend in HI
                if (op_q[1]) begin
                    if (opb == '0) begin
                        lo_next = '1;
                        hi_next = raw_a;
                    end else begin
                        lo_next = neg ? -quot : quot;
                        hi_next = sign_a ? -rem : rem;
                    end
                end else begin
                    {hi_next, lo_next} = product;
                end
                busy_next  = 1'b0;
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            op_q   <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            opa    <= opa_next;
            opb    <= opb_next;
            acc    <= acc_next;
            op_q   <= op_q_next;
            sign_a <= sign_a_next;
            sign_b <= sign_b_next;
            hi     <= hi_next;
            lo     <= lo_next;
            busy   <= busy_next;
            done   <= done_next;
        end
    end

    assign md_result = rd_hi ? hi : lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: an arithmetic HI/LO model checked every cycle,
// plus literal expectations for each directed operation.
module tb_md_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic [31:0] wdata = '0;
    logic        rd_hi = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo, md_result;

    int n_chk  = 0;
    int n_fail = 0;

    md_unit #(.XLEN(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata), .rd_hi(rd_hi),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .md_result(md_result)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference result {hi, lo} straight from MIPS arithmetic
    function automatic logic [63:0] model_op(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
        longint sx, sy, q, r, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: begin
                p = sx * sy;
                return 64'(p);
            end
            2'b01: return {32'd0, x} * {32'd0, y};
            2'b10: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    logic        m_busy = 1'b0, m_done = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int          m_cnt = 0;

    // Model: 33 edges after acceptance the result lands and done pulses
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_cnt  <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_cnt == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_hi   <= p_hi;
                    m_lo   <= p_lo;
                end
                m_cnt <= m_cnt - 1;
            end else if (start) begin
                {p_hi, p_lo} <= model_op(op, a, b);
                m_busy       <= 1'b1;
                m_cnt        <= 33;
            end else begin
                if (wr_hi) m_hi <= wdata;
                if (wr_lo) m_lo <= wdata;
            end
        end
    end

    always @(negedge clock) begin
        chk("cyc_busy", 32'(busy), 32'(m_busy));
        chk("cyc_done", 32'(done), 32'(m_done));
        chk("cyc_hi", hi, m_hi);
        chk("cyc_lo", lo, m_lo);
        chk("cyc_md_result", md_result, rd_hi ? m_hi : m_lo);
    end

    // poke: 0 none, 1 new start at cycle 5, 2 mthi at cycle 5, 4 mthi alongside start
    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] ehi,
                          input logic [31:0] elo, input int poke);
        int cyc = 0;
        int dn = 0;
        @(negedge clock);
        #1;
        start = 1'b1; op = o; a = x; b = y;
        if (poke == 4) begin wr_hi = 1'b1; wdata = 32'h0000_DEAD; end
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (busy) cyc++;
            if (done) dn++;
            if (!busy) break;
            #1;
            start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
            a = 32'hA5A5_0F0F; b = 32'h1357_9BDF;
            if (cyc == 5 && poke == 1) begin start = 1'b1; op = 2'b11; a = 32'd5; b = 32'd1; end
            if (cyc == 5 && poke == 2) begin wr_hi = 1'b1; wdata = 32'h0000_DEAD; end
        end
        chk({nm, "_busy_cycles"}, 32'(cyc), 32'd33);
        chk({nm, "_done_pulses"}, 32'(dn), 32'd1);
        chk({nm, "_hi"}, hi, ehi);
        chk({nm, "_lo"}, lo, elo);
    endtask

    initial begin
        int dn;
        @(negedge clock);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        #1 reset = 1'b0;

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0);
        run_op("divu_zero", 2'b11, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 0);
        run_op("div_negdiv", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 0);
        run_op("div_zero_s", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0);
        run_op("start_busy", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1);
        run_op("mthi_busy", 2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 2);

        // mtlo while idle, then mthi+mtlo together
        @(negedge clock);
        #1 wr_lo = 1'b1; wdata = 32'h0000_BEEF; rd_hi = 1'b0;
        @(negedge clock);
        #1 wr_lo = 1'b0;
        chk("mtlo_lo", lo, 32'h0000_BEEF);
        chk("mtlo_md_result", md_result, 32'h0000_BEEF);
        chk("mtlo_hi_kept", hi, 32'd0);
        chk("mtlo_no_done", 32'(done), 32'd0);
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h5A5A_5A5A;
        @(negedge clock);
        #1 wr_hi = 1'b0; wr_lo = 1'b0; rd_hi = 1'b1;
        #1;
        chk("mtboth_hi", hi, 32'h5A5A_5A5A);
        chk("mtboth_lo", lo, 32'h5A5A_5A5A);
        chk("mtboth_md_result", md_result, 32'h5A5A_5A5A);

        run_op("start_mthi", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 4);

        // Asynchronous reset partway through a mult
        @(negedge clock);
        #1 start = 1'b1; op = 2'b00; a = 32'h0001_2345; b = 32'h0000_0777;
        @(negedge clock);
        #1 start = 1'b0;
        repeat (9) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        chk("arst_md_result", md_result, 32'd0);
        @(negedge clock);
        #1 reset = 1'b0;
        dn = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) dn++;
        end
        chk("arst_no_done", 32'(dn), 32'd0);
        run_op("after_rst", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);

        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
